pipeline_sequencer: RTL and testbench
=====================================

// Module: pipeline_sequencer
// PURPOSE
//  Central stall/flush sequencer for the 5-stage Otter pipeline. Consumes the
//  load-use and control hazard flags from the hazard/forwarding logic, plus the
//  data-memory handshake. Drives every pipeline-register enable, the PC write
//  enable and the DE/EX bubble-insert flushes. Also keeps saturating stall and
//  flush performance counters, and a sticky bus-error flag for memory timeouts.
// PARAMETERS
//  CNT_W        32  width of stall_cnt / flush_cnt performance counters
//  MEM_TIMEOUT  15  consecutive frozen memory-wait cycles before bus error (>=2)
// PORTS
//  CLK          in   1      system clock, rising edge
//  RST          in   1      asynchronous, active-high reset
//  load_use_haz in   1      DE reads rd of a load currently in EX
//  control_haz  in   1      jal/jalr/taken branch resolved in EX (pc_source!=0)
//  mem_req      in   1      MEM stage holds a load/store; held while MEM frozen
//  mem_ack      in   1      data memory completes the MEM-stage access this cycle
//  pc_we        out  1      PC register write enable
//  if_en        out  1      IF/DE register enable
//  de_en        out  1      DE/EX register enable
//  ex_en        out  1      EX/MEM register enable
//  mem_en       out  1      MEM/WB register enable
//  de_flush     out  1      load NOP into IF/DE (overrides hold)
//  ex_flush     out  1      load NOP into DE/EX (overrides hold)
//  mem_busy     out  1      pipeline frozen waiting on mem_ack
//  bus_err      out  1      sticky: memory access timed out
//  stall_cnt    out  CNT_W  cycles with pc_we=0 outside ERR and reset
//  flush_cnt    out  CNT_W  cycles with de_flush=1
// BEHAVIOUR
//  States: RUN, MEM_WAIT, ERR (registered). wait_cnt: internal, clog2(MEM_TIMEOUT+1) bits.
//  Reset (RST high, async): state=RUN, wait_cnt=0, bus_err=0, counters=0.
//   While RST high: pc_we/en all 0, de_flush=ex_flush=1, mem_busy=0.
//   Reset mid-MEM_WAIT or in ERR returns to RUN and clears the timer.
//  Outputs are combinational from state + inputs (zero latency). Priority: memory > control > load-use.
//  RUN, mem_req & !mem_ack: freeze. pc_we/if_en/de_en/ex_en/mem_en=0, flushes=0,
//   mem_busy=1. Next state MEM_WAIT, wait_cnt<=1. Hazard inputs are ignored.
//  RUN, control_haz, no mem wait: all enables 1, pc_we=1, de_flush=ex_flush=1.
//   A simultaneous load_use_haz is ignored; DE is flushed anyway.
//  RUN, load_use_haz only: pc_we=if_en=de_en=0, ex_en=mem_en=1, ex_flush=1,
//   de_flush=0. Inserts exactly one bubble per asserted cycle.
//  RUN, none: all enables 1, pc_we=1, flushes 0.
//  MEM_WAIT, !mem_ack: same freeze outputs, mem_busy=1, wait_cnt++.
//   If wait_cnt==MEM_TIMEOUT, next state is ERR.
//  MEM_WAIT, mem_ack: outputs as in RUN, evaluated on current hazard inputs.
//   Next state RUN, wait_cnt<=0. An ack on the timeout cycle wins over error.
//  ERR: all enables/pc_we 0, flushes 0, mem_busy=0, bus_err=1. Exit only by RST.
//  bus_err: registered; first high in the cycle state==ERR.
//  Counters: +1 per qualifying cycle and saturate at all-ones (no wrap).
//   No counting while RST is high or in ERR.
//  mem_ack while mem_req=0 is ignored. mem_req is level; no new request while frozen.
// TESTING
//  T1 reset: assert RST mid-cycle -> immediately pc_we=0, de_flush=ex_flush=1.
//     Release -> pc_we=1, all en=1, counters=0, bus_err=0.
//  T2 load-use: load_use_haz=1 for 1 cycle -> that cycle pc_we=if_en=de_en=0,
//     ex_flush=1. stall_cnt=1 next cycle; flush_cnt=0.
//  T3 control: control_haz=1 with load_use_haz=1 -> de_flush=ex_flush=1, pc_we=1.
//     flush_cnt=1, stall_cnt unchanged.
//  T4 mem wait: mem_req=1, ack on 4th cycle -> 3 cycles mem_busy=1 with all en=0.
//     Ack cycle en=1; stall_cnt=3; state back to RUN.
//  T5 timeout (MEM_TIMEOUT=15): mem_req=1, never ack -> 15 frozen cycles, then ERR.
//     bus_err=1 and en=0 held for 20+ cycles; RST clears bus_err. Ack on 15th cycle -> no ERR.
//  T6 saturation (CNT_W=4): 20 load-use cycles -> stall_cnt=4'hF held, no wrap to 0.

Source files
------------

// File: rtl/pipeline_sequencer.sv
// Otter pipeline stall/flush sequencer: register enables, bubble flushes,
// memory-wait freeze with timeout, and saturating stall/flush counters.
module pipeline_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load_use_haz,
  input  logic             control_haz,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_we,
  output logic             if_en,
  output logic             de_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             de_flush,
  output logic             ex_flush,
  output logic             mem_busy,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERR
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              freeze;

  // Once in MEM_WAIT the request is held, so only the ack matters.
  always_comb begin
    freeze = 1'b0;
    unique case (state)
      RUN:      freeze = mem_req & ~mem_ack;
      MEM_WAIT: freeze = ~mem_ack;
      default:  freeze = 1'b0;
    endcase
  end

  always_comb begin
    pc_we    = 1'b0;
    if_en    = 1'b0;
    de_en    = 1'b0;
    ex_en    = 1'b0;
    mem_en   = 1'b0;
    de_flush = 1'b0;
    ex_flush = 1'b0;
    mem_busy = 1'b0;
    priority case (1'b1)
      RST: begin
        de_flush = 1'b1;
        ex_flush = 1'b1;
      end
      state == ERR: begin
        mem_busy = 1'b0;
      end
      freeze: begin
        mem_busy = 1'b1;
      end
      control_haz: begin
        pc_we    = 1'b1;
        if_en    = 1'b1;
        de_en    = 1'b1;
        ex_en    = 1'b1;
        mem_en   = 1'b1;
        de_flush = 1'b1;
        ex_flush = 1'b1;
      end
      load_use_haz: begin
        ex_en    = 1'b1;
        mem_en   = 1'b1;
        ex_flush = 1'b1;
      end
      default: begin
        pc_we  = 1'b1;
        if_en  = 1'b1;
        de_en  = 1'b1;
        ex_en  = 1'b1;
        mem_en = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= RUN;
      wait_cnt  <= '0;
      bus_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state != ERR && !pc_we && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (de_flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
      unique case (state)
        RUN: begin
          if (freeze) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
            // This cycle is the MEM_TIMEOUT-th frozen cycle.
            if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
              state   <= ERR;
              bus_err <= 1'b1;
            end
          end
        end
        default: begin
          state <= ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed and randomized bench for pipeline_sequencer against a
// cycle-count reference model (CNT_W=4, MEM_TIMEOUT=15).
module tb_pipeline_sequencer;

  localparam int CMAX = 15;
  localparam int TMO  = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_use_haz, control_haz, mem_req, mem_ack;
  logic       pc_we, if_en, de_en, ex_en, mem_en;
  logic       de_flush, ex_flush, mem_busy, bus_err;
  logic [3:0] stall_cnt, flush_cnt;
  logic [7:0] outs;

  int checks = 0;
  int passed = 0;

  int m_stall, m_flush, m_run;
  bit m_err;

  always #5 clk = ~clk;

  pipeline_sequencer #(
    .CNT_W      (4),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .load_use_haz(load_use_haz),
    .control_haz (control_haz),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .pc_we       (pc_we),
    .if_en       (if_en),
    .de_en       (de_en),
    .ex_en       (ex_en),
    .mem_en      (mem_en),
    .de_flush    (de_flush),
    .ex_flush    (ex_flush),
    .mem_busy    (mem_busy),
    .bus_err     (bus_err),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  assign outs = {pc_we, if_en, de_en, ex_en, mem_en,
                 de_flush, ex_flush, mem_busy};

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected {pc_we,if,de,ex,mem,de_flush,ex_flush,busy} for this cycle.
  function automatic logic [7:0] exp_out(bit lu, bit ch, bit req, bit ack);
    if (m_err)       return 8'b00000_000;
    if (req && !ack) return 8'b00000_001;
    if (ch)          return 8'b11111_110;
    if (lu)          return 8'b00011_010;
    return 8'b11111_000;
  endfunction

  task automatic reset_dut();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_outs", outs, 8'b00000_110);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_flush", flush_cnt, 0);
    chk("rst_bus_err", bus_err, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    m_stall = 0;
    m_flush = 0;
    m_run   = 0;
    m_err   = 1'b0;
  endtask

  task automatic step(bit lu, bit ch, bit req, bit ack);
    logic [7:0] e;
    load_use_haz = lu;
    control_haz  = ch;
    mem_req      = req;
    mem_ack      = ack;
    @(negedge clk);
    e = exp_out(lu, ch, req, ack);
    chk("outs", outs, e);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    chk("bus_err", bus_err, m_err);
    if (!m_err) begin
      if (!e[7]) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (e[2])  m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      m_run = e[0] ? m_run + 1 : 0;
      if (m_run == TMO) m_err = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ackp;
    rst          = 1'b0;
    load_use_haz = 1'b0;
    control_haz  = 1'b0;
    mem_req      = 1'b0;
    mem_ack      = 1'b0;
    m_stall = 0;
    m_flush = 0;
    m_run   = 0;
    m_err   = 1'b0;

    // T1 reset and release
    reset_dut();
    step(0, 0, 0, 0);

    // T2 single load-use bubble
    step(1, 0, 0, 0);
    chk("t2_stall", stall_cnt, 1);
    chk("t2_flush", flush_cnt, 0);

    // T3 control beats load-use
    step(1, 1, 0, 0);
    chk("t3_flush", flush_cnt, 1);
    chk("t3_stall", stall_cnt, 1);

    // T4 memory wait acked on 4th cycle
    reset_dut();
    repeat (3) step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    chk("t4_stall", stall_cnt, 3);
    step(0, 0, 0, 0);

    // T5 timeout then sticky error
    reset_dut();
    repeat (TMO) step(0, 0, 1, 0);
    repeat (22) step(1, 1, 1, 0);
    chk("t5_bus_err", bus_err, 1);
    reset_dut();
    repeat (TMO - 1) step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    repeat (5) step(0, 0, 0, 0);
    chk("t5_ack_last", bus_err, 0);

    // T6 saturation
    reset_dut();
    repeat (20) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t6_sat", stall_cnt, 4'hF);

    // Randomized traffic
    reset_dut();
    ackp = 40;
    for (int i = 0; i < 400; i++) begin
      bit req, ack;
      if (m_err && $urandom_range(0, 7) == 0) reset_dut();
      if (m_run == 0) ackp = ($urandom_range(0, 3) == 0) ? 2 : 40;
      req = (m_run > 0) || ($urandom_range(0, 2) == 0);
      ack = $urandom_range(0, 99) < ackp;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, req, ack);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
